// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings up the upstream PLL, qualifies its (asynchronous) locked flag, then
//   releases per-domain resets in order, domain 0 first. Lock loss or a
//   restart request re-asserts every reset and re-runs the bring-up; repeated
//   lock timeouts end in FAULT until restart_req or rst.
//   Optional build macro: PLL_SEQ_LOSS_COUNTER_EN enables the saturating
//   lock-loss counter; when undefined lock_loss_cnt is tied to zero.
module pll_lock_sequencer #(
    parameter int unsigned NUM_DOMAINS  = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned RELEASE_GAP  = 8,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   restart_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   fault,
    output logic [2:0]             retry_cnt,
    output logic [7:0]             lock_loss_cnt
);

    localparam int unsigned MAX_TS  = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int unsigned MAX_RG  = (RST_CYCLES > RELEASE_GAP) ? RST_CYCLES : RELEASE_GAP;
    localparam int unsigned MAX_ALL = (MAX_TS > MAX_RG) ? MAX_TS : MAX_RG;
    localparam int unsigned CNT_W   = ($clog2(MAX_ALL) > 0) ? $clog2(MAX_ALL) : 1;
    localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] domain_rst_q;
    logic                   ready_q;
    logic                   fault_q;
    logic [2:0]             retry_q;
    logic [2:0]             retry_inc;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   lock_lost;

    // Bring the asynchronous PLL lock flag into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s  = sync_q[SYNC_STAGES-1];
    assign retry_inc = retry_q + 3'd1;
    // Lock loss only matters once resets have started to be released.
    assign lock_lost = !locked_s && ((state_q == S_RELEASE) || (state_q == S_RUN));

    // Bring-up sequencer: state, shared counter, release index and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            idx_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
        end else if (restart_req) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            idx_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
        end else if (lock_lost) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            idx_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    pll_rst_q    <= 1'b1;
                    domain_rst_q <= '1;
                    if (cnt_q == RST_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_q   <= retry_inc;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= S_RESET_PLL;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        retry_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        domain_rst_q[idx_q] <= 1'b0;
                        cnt_q               <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    ready_q      <= 1'b1;
                    domain_rst_q <= '0;
                end
                S_FAULT: begin
                    pll_rst_q    <= 1'b1;
                    domain_rst_q <= '1;
                    fault_q      <= 1'b1;
                end
                default: begin
                    state_q      <= S_RESET_PLL;
                    cnt_q        <= '0;
                    idx_q        <= '0;
                    pll_rst_q    <= 1'b1;
                    domain_rst_q <= '1;
                    ready_q      <= 1'b0;
                    fault_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst    = pll_rst_q;
    assign domain_rst = domain_rst_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_q;

`ifdef PLL_SEQ_LOSS_COUNTER_EN
    logic [7:0] loss_cnt_q;
    logic [7:0] loss_cnt_d;

    // A restart coinciding with lock loss is not counted; saturate at 255.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost && !restart_req && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    // Lock-loss count survives restart_req; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule
